// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: register map, frame size and FSM encoding shared by the SPI register bank.
package spi_reg_pkg;
  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;
  localparam int FRAME_BITS = 16;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for an async pin with 1-clk rise/fall pulses.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] s;
  logic d;
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= {STAGES{RST_VAL}};
      d <= RST_VAL;
    end else begin
      s <= {s[STAGES-2:0], din};
      d <= s[STAGES-1];
    end
  end
  assign sync = s[STAGES-1];
  assign rise = sync & ~d;
  assign fall = ~sync & d;
endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 write-only slave feeding the pwm_peripheral enable and duty registers.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);
  localparam int AW = $clog2(NUM_REGS);
  logic sclk_rise, ncs_fall, ncs_rise, copi_s, fall_pend, hit;
  logic [FRAME_BITS-1:0] sr;
  logic [4:0] cnt;
  logic [6:0] addr;
  logic [7:0] regs [NUM_REGS];
  state_t state, state_n;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(sclk), .sync(), .rise(sclk_rise), .fall()
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst(rst), .din(ncs), .sync(), .rise(ncs_rise), .fall(ncs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst(rst), .din(copi), .sync(copi_s), .rise(), .fall()
  );
  assign addr = sr[14:8];
  assign hit  = cnt == 5'(FRAME_BITS) && sr[15] && 32'(addr) < NUM_REGS;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE  ? ((ncs_fall | fall_pend) ? SHIFT : IDLE) :
              state == SHIFT ? (ncs_rise ? COMMIT : SHIFT) : IDLE;
  end
  // an ncs fall landing in COMMIT is held one clk so IDLE still sees it
  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      cnt       <= '0;
      fall_pend <= 1'b0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      regs      <= '{default: '0};
    end else begin
      fall_pend <= state == COMMIT && ncs_fall;
      wr_strobe <= state == COMMIT && hit;
      frame_err <= state == COMMIT && cnt != 5'(FRAME_BITS);
      if (state == IDLE && (ncs_fall | fall_pend))
        cnt <= '0;
      else if (state == SHIFT && sclk_rise) begin
        sr  <= {sr[FRAME_BITS-2:0], copi_s};
        cnt <= cnt == 5'(FRAME_BITS + 1) ? cnt : cnt + 5'd1;
      end
      if (state == COMMIT && hit)
        regs[addr[AW-1:0]] <= sr[7:0];
    end
  end
  assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO[AW-1:0]];
  assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI[AW-1:0]];
  assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO[AW-1:0]];
  assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI[AW-1:0]];
  assign pwm_duty_cycle  = regs[ADDR_PWM_DUTY[AW-1:0]];
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed SPI frames against hand-computed register contents and pulse counts.
module tb_spi_reg_bank;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, ncs = 1'b1, copi = 1'b0;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
  logic wr_strobe, frame_err;
  int n_vec = 0, n_bad = 0, n_wr = 0, n_err = 0;
  spi_reg_bank dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi),
    .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
    .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi),
    .pwm_duty_cycle(duty), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && wr_strobe) n_wr++;
    if (!rst && frame_err) n_err++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk_regs(input string tag, input int a, input int b, input int c, input int d, input int e);
    chk({tag, ".out_lo"}, out_lo, a);
    chk({tag, ".out_hi"}, out_hi, b);
    chk({tag, ".pwm_lo"}, pwm_lo, c);
    chk({tag, ".pwm_hi"}, pwm_hi, d);
    chk({tag, ".duty"}, duty, e);
  endtask
  // leaves ncs high on return; tied raises ncs together with the last sclk rise
  task automatic send_frame(input logic [15:0] w, input int nbits, input bit tied);
    logic [16:0] ext;
    ext = {w, 1'b0};
    ncs = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      copi = ext[16-i];
      wait_clk(4);
      sclk = 1'b1;
      if (tied && i == nbits - 1) begin
        ncs = 1'b1;
        return;
      end
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(4);
    ncs = 1'b1;
  endtask
  task automatic frame(input logic [15:0] w, input int nbits);
    send_frame(w, nbits, 1'b0);
    wait_clk(6);
  endtask
  initial begin
    int w0, e0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2);
    chk_regs("reset", 0, 0, 0, 0, 0);
    chk("reset.wr_strobe", wr_strobe, 0);
    chk("reset.frame_err", frame_err, 0);
    send_frame(16'h8480, 16, 1'b0);
    wait_clk(3);
    chk("lat.early_strobe", wr_strobe, 0);
    chk("lat.early_duty", duty, 0);
    wait_clk(1);
    chk("lat.strobe", wr_strobe, 1);
    chk("lat.duty", duty, 8'h80);
    wait_clk(1);
    chk("lat.strobe_end", wr_strobe, 0);
    wait_clk(2);
    chk_regs("t1", 0, 0, 0, 0, 8'h80);
    chk("t1.wr_count", n_wr, 1);
    frame(16'h80F0, 16);
    frame(16'h810F, 16);
    frame(16'h82AA, 16);
    frame(16'h8355, 16);
    chk_regs("t2", 8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h80);
    chk("t2.wr_count", n_wr, 5);
    frame(16'h0012, 16);
    frame(16'hB0FF, 16);
    chk_regs("t3", 8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h80);
    chk("t3.wr_count", n_wr, 5);
    chk("t3.err_count", n_err, 0);
    frame(16'h8499, 15);
    chk("t4.err15", n_err, 1);
    frame(16'h8499, 17);
    chk("t4.err17", n_err, 2);
    chk_regs("t4", 8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h80);
    chk("t4.wr_count", n_wr, 5);
    w0 = n_wr;
    e0 = n_err;
    ncs = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 9; i++) begin
      copi = (i == 0);
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    rst = 1'b1;
    ncs = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(6);
    chk_regs("t5.rst", 0, 0, 0, 0, 0);
    chk("t5.wr_none", n_wr, w0);
    chk("t5.err_none", n_err, e0);
    frame(16'h8233, 16);
    chk_regs("t5.after", 0, 0, 8'h33, 0, 0);
    chk("t5.err_after", n_err, e0);
    w0 = n_wr;
    send_frame(16'h8011, 16, 1'b1);
    wait_clk(4);
    sclk = 1'b0;
    chk("t6.first", out_lo, 8'h11);
    send_frame(16'h8022, 16, 1'b1);
    wait_clk(4);
    sclk = 1'b0;
    chk("t6.second", out_lo, 8'h22);
    wait_clk(4);
    chk("t6.wr_count", n_wr - w0, 2);
    chk("t6.err_count", n_err, e0);
    chk_regs("t6", 8'h22, 0, 8'h33, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
